// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system bus switch.
// Holds the FSM state encoding, the read-data pattern returned on a bus error,
// and a helper that sizes the slave-index field.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Wide all-ones pattern; users truncate to their data width.
    localparam int unsigned ERR_RDATA_W = 1024;
    localparam logic [ERR_RDATA_W-1:0] ERR_RDATA = '1;

    // Width of a slave index; at least one bit even for a single slave.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/sys_bus_decoder.sv
// Combinational address decoder for the system bus switch.
// Ports:
//   addr_i  - byte address to decode
//   match_o - high when any slave region contains addr_i
//   idx_o   - index of the matching slave (lowest index wins on overlap)
module sys_bus_decoder
    import sys_bus_pkg::*;
#(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned IDX_W   = idx_width(NUM_SLV),
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              match_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Scan from the highest index down so the lowest matching index is left last.
    always_comb begin
        match_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                match_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sys_bus_switch.sv
// Single-master to multi-slave bus switch with address decode and ack timeout.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   m_addr/m_read/m_write  - master request (held stable while m_stall is high)
//   m_wdata/m_byte_en      - master write data and byte enables
//   m_rdata                - read data, valid in the DONE cycle (all-ones after error)
//   m_stall                - master wait
//   m_err                  - one-cycle bus-error pulse
//   s_addr                 - in-region offset of the latched address
//   s_wdata/s_byte_en      - latched write data and byte enables
//   s_read/s_write         - one-hot strobes, active only in ACCESS
//   s_rdata/s_ack          - per-slave read data and completion
module sys_bus_switch
    import sys_bus_pkg::*;
#(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic                      m_read,
    input  logic                      m_write,
    input  logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W/8-1:0]       m_byte_en,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_stall,
    output logic                      m_err,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    output logic [DATA_W/8-1:0]       s_byte_en,
    output logic [NUM_SLV-1:0]        s_read,
    output logic [NUM_SLV-1:0]        s_write,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_ack
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = idx_width(NUM_SLV);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] RD_ERR = DATA_W'(ERR_RDATA);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               dec_match;
    logic [IDX_W-1:0]   dec_idx;
    logic               req_c;
    logic               ack_c;
    logic [DATA_W-1:0]  sel_rdata_c;
    logic [NUM_SLV-1:0] sel_onehot_c;

    sys_bus_decoder #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decoder (
        .addr_i  (m_addr),
        .match_o (dec_match),
        .idx_o   (dec_idx)
    );

    assign req_c        = m_read | m_write;
    assign ack_c        = s_ack[sel_q];
    assign sel_rdata_c  = s_rdata[sel_q*DATA_W +: DATA_W];
    assign sel_onehot_c = NUM_SLV'(1) << sel_q;

    // Transaction state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    be_d    = m_byte_en;
                    wr_d    = m_write;
                    sel_d   = dec_idx;
                    cnt_d   = '0;
                    // Simultaneous read and write is treated as an undecodable request.
                    if (dec_match && !(m_read && m_write)) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_ERR;
                        rdata_d = RD_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack takes priority over a timeout in the same cycle.
                if (ack_c) begin
                    state_d = ST_DONE;
                    if (!wr_q) begin
                        rdata_d = sel_rdata_c;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    cnt_d   = CNT_W'(TIMEOUT);
                    rdata_d = RD_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign s_read    = (state_q == ST_ACCESS && !wr_q) ? sel_onehot_c : '0;
    assign s_write   = (state_q == ST_ACCESS &&  wr_q) ? sel_onehot_c : '0;
    assign s_addr    = addr_q & ~SLV_MASK[sel_q*ADDR_W +: ADDR_W];
    assign s_wdata   = wdata_q;
    assign s_byte_en = be_q;
    assign m_rdata   = rdata_q;
    assign m_err     = (state_q == ST_ERR);
    // Stall covers the accepting IDLE cycle combinationally; forced low during reset.
    assign m_stall   = !rst && (((state_q == ST_IDLE) && req_c) ||
                                (state_q == ST_ACCESS) || (state_q == ST_ERR));

endmodule
